// File: rtl/param_pkg.sv
// Shared definitions for the double-buffered parameter bank controller.
//   PARAM_WIDTH_DEF / ADDR_WIDTH_DEF : default word width and address width
//   bank_state_t                     : controller FSM states
//   param_t                          : one parameter word at the default width
package param_pkg;

  localparam int unsigned PARAM_WIDTH_DEF = 36;
  localparam int unsigned ADDR_WIDTH_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SWAP,
    COPY
  } bank_state_t;

  typedef logic [PARAM_WIDTH_DEF-1:0] param_t;

endpackage

// File: rtl/param_bank_ram.sv
// One parameter bank: a single synchronous write port and two synchronous read ports.
//   clk_i, rst_i         : clock, async active-high reset (clears read registers only)
//   we_i/waddr_i/wdata_i : write port
//   addr_a_i / rdata_a_o : read port A (DSP or SPI readback), 1-cycle latency
//   addr_b_i / rdata_b_o : read port B (copy engine), 1-cycle latency
// Reads return the pre-write contents when the same address is written in the same cycle.
module param_bank_ram #(
  parameter int unsigned PARAM_WIDTH = 36,
  parameter int unsigned ADDR_WIDTH  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   we_i,
  input  logic [ADDR_WIDTH-1:0]  waddr_i,
  input  logic [PARAM_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0]  addr_a_i,
  output logic [PARAM_WIDTH-1:0] rdata_a_o,
  input  logic [ADDR_WIDTH-1:0]  addr_b_i,
  output logic [PARAM_WIDTH-1:0] rdata_b_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [PARAM_WIDTH-1:0] mem [DEPTH];
  logic [PARAM_WIDTH-1:0] rdata_a_q, rdata_b_q;

  // Storage is deliberately not reset; the host rewrites the full map after reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      rdata_a_q <= mem[addr_a_i];
      rdata_b_q <= mem[addr_b_i];
    end
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/param_bank_ctrl.sv
// Double-buffered parameter memory controller between the SPI slave and the DSP core.
// SPI writes land in the shadow bank; a validated transaction arms a commit; the next
// frame_start swaps banks, then the new active bank is copied into the new shadow bank.
//   clk, rst                         : clock, async active-high reset
//   spi_active, spi_valid            : SPI transaction framing and status
//   spi_wr_addr/data/enable          : SPI write into shadow bank
//   spi_rd_addr / spi_rd_data        : shadow readback, 1-cycle latency
//   dsp_rd_addr / dsp_rd_data        : active-bank read, 1-cycle latency
//   frame_start                      : audio frame boundary pulse
//   active_bank, commit_pending,
//   busy, wr_overrun                 : registered status
module param_bank_ctrl
  import param_pkg::*;
#(
  parameter int unsigned PARAM_WIDTH = PARAM_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   spi_active,
  input  logic                   spi_valid,
  input  logic [ADDR_WIDTH-1:0]  spi_wr_addr,
  input  logic [PARAM_WIDTH-1:0] spi_wr_data,
  input  logic                   spi_wr_enable,
  input  logic [ADDR_WIDTH-1:0]  spi_rd_addr,
  output logic [PARAM_WIDTH-1:0] spi_rd_data,
  input  logic [ADDR_WIDTH-1:0]  dsp_rd_addr,
  output logic [PARAM_WIDTH-1:0] dsp_rd_data,
  input  logic                   frame_start,
  output logic                   active_bank,
  output logic                   commit_pending,
  output logic                   busy,
  output logic                   wr_overrun
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_LAST = DEPTH[ADDR_WIDTH:0];

  bank_state_t           state_q, state_d;
  logic                  active_bank_q, active_bank_d;
  logic                  commit_pending_q, commit_pending_d;
  logic                  busy_q, busy_d;
  logic                  wr_overrun_q, wr_overrun_d;
  logic                  wrote_any_q, wrote_any_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  spi_active_q;
  logic                  rd_sel_q;

  logic                  spi_rise, spi_fall;
  logic                  wr_accept, copy_wr, shadow_we;
  logic [ADDR_WIDTH-1:0] copy_raddr, copy_waddr, shadow_waddr;
  logic [PARAM_WIDTH-1:0] shadow_wdata, copy_rdata;
  logic                  we0, we1;
  logic [ADDR_WIDTH-1:0] addr_a0, addr_a1;
  logic [PARAM_WIDTH-1:0] rdata_a0, rdata_a1, rdata_b0, rdata_b1;

  assign spi_rise  = spi_active & ~spi_active_q;
  assign spi_fall  = ~spi_active & spi_active_q;
  assign wr_accept = spi_wr_enable && (state_q == IDLE);

  // Copy pipeline: read address cnt in one cycle, write address cnt-1 the next.
  // At cnt == DEPTH the low bits wrap to 0, so cnt-1 lands on DEPTH-1.
  assign copy_wr    = (state_q == COPY) && (cnt_q != '0);
  assign copy_raddr = cnt_q[ADDR_WIDTH-1:0];
  assign copy_waddr = cnt_q[ADDR_WIDTH-1:0] - 1'b1;
  assign copy_rdata = active_bank_q ? rdata_b1 : rdata_b0;

  // SPI writes are only accepted in IDLE and copy writes only occur in COPY.
  assign shadow_we    = wr_accept | copy_wr;
  assign shadow_waddr = copy_wr ? copy_waddr : spi_wr_addr;
  assign shadow_wdata = copy_wr ? copy_rdata : spi_wr_data;

  // The active bank is never written; only the shadow bank sees the write port.
  assign we0 = shadow_we & active_bank_q;
  assign we1 = shadow_we & ~active_bank_q;

  assign addr_a0 = active_bank_q ? spi_rd_addr : dsp_rd_addr;
  assign addr_a1 = active_bank_q ? dsp_rd_addr : spi_rd_addr;

  param_bank_ram #(
    .PARAM_WIDTH (PARAM_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_bank0 (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (we0),
    .waddr_i   (shadow_waddr),
    .wdata_i   (shadow_wdata),
    .addr_a_i  (addr_a0),
    .rdata_a_o (rdata_a0),
    .addr_b_i  (copy_raddr),
    .rdata_b_o (rdata_b0)
  );

  param_bank_ram #(
    .PARAM_WIDTH (PARAM_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_bank1 (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (we1),
    .waddr_i   (shadow_waddr),
    .wdata_i   (shadow_wdata),
    .addr_a_i  (addr_a1),
    .rdata_a_o (rdata_a1),
    .addr_b_i  (copy_raddr),
    .rdata_b_o (rdata_b1)
  );

  // Read data is steered by the bank that was active when the address was issued,
  // so a read straddling the swap edge never mixes banks.
  assign dsp_rd_data = rd_sel_q ? rdata_a1 : rdata_a0;
  assign spi_rd_data = rd_sel_q ? rdata_a0 : rdata_a1;

  always_comb begin
    state_d       = state_q;
    active_bank_d = active_bank_q;
    cnt_d         = cnt_q;
    wrote_any_d   = wrote_any_q;
    wr_overrun_d  = wr_overrun_q;

    if (spi_rise) wrote_any_d = 1'b0;
    if (wr_accept) wrote_any_d = 1'b1;

    if (spi_rise && (state_q == IDLE)) wr_overrun_d = 1'b0;
    if (spi_wr_enable && (state_q != IDLE)) wr_overrun_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        // frame_start is not looked at here, so a coincident pulse cannot trigger the swap.
        if (spi_fall && spi_valid && (wrote_any_q || wr_accept)) begin
          state_d     = ARMED;
          wrote_any_d = 1'b0;
        end
      end
      ARMED: begin
        if (frame_start) state_d = SWAP;
      end
      SWAP: begin
        active_bank_d = ~active_bank_q;
        cnt_d         = '0;
        state_d       = COPY;
      end
      COPY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    commit_pending_d = (state_d == ARMED) || (state_d == SWAP);
    busy_d           = (state_d == SWAP) || (state_d == COPY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      active_bank_q    <= 1'b0;
      commit_pending_q <= 1'b0;
      busy_q           <= 1'b0;
      wr_overrun_q     <= 1'b0;
      wrote_any_q      <= 1'b0;
      cnt_q            <= '0;
      spi_active_q     <= 1'b0;
      rd_sel_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      active_bank_q    <= active_bank_d;
      commit_pending_q <= commit_pending_d;
      busy_q           <= busy_d;
      wr_overrun_q     <= wr_overrun_d;
      wrote_any_q      <= wrote_any_d;
      cnt_q            <= cnt_d;
      spi_active_q     <= spi_active;
      rd_sel_q         <= active_bank_q;
    end
  end

  assign active_bank    = active_bank_q;
  assign commit_pending = commit_pending_q;
  assign busy           = busy_q;
  assign wr_overrun     = wr_overrun_q;

endmodule

// File: tb/tb_param_bank_ctrl.sv
// Scoreboard bench for param_bank_ctrl: stimulus pushes expected read data into queues,
// a negedge monitor pops and compares whenever a tracked read returns.
module tb_param_bank_ctrl;

  localparam int unsigned PW    = 36;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          spi_active = 1'b0;
  logic          spi_valid = 1'b0;
  logic [AW-1:0] spi_wr_addr = '0;
  logic [PW-1:0] spi_wr_data = '0;
  logic          spi_wr_enable = 1'b0;
  logic [AW-1:0] spi_rd_addr = '0;
  logic [PW-1:0] spi_rd_data;
  logic [AW-1:0] dsp_rd_addr = '0;
  logic [PW-1:0] dsp_rd_data;
  logic          frame_start = 1'b0;
  logic          active_bank, commit_pending, busy, wr_overrun;

  param_bank_ctrl #(
    .PARAM_WIDTH (PW),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .spi_active     (spi_active),
    .spi_valid      (spi_valid),
    .spi_wr_addr    (spi_wr_addr),
    .spi_wr_data    (spi_wr_data),
    .spi_wr_enable  (spi_wr_enable),
    .spi_rd_addr    (spi_rd_addr),
    .spi_rd_data    (spi_rd_data),
    .dsp_rd_addr    (dsp_rd_addr),
    .dsp_rd_data    (dsp_rd_data),
    .frame_start    (frame_start),
    .active_bank    (active_bank),
    .commit_pending (commit_pending),
    .busy           (busy),
    .wr_overrun     (wr_overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Bank model indexed by physical bank, plus the bench's own idea of the active bank.
  logic [PW-1:0] m_bank [2][DEPTH];
  logic          exp_active = 1'b0;
  logic          chk_en = 1'b0;

  logic [PW-1:0] dsp_exp_q [$];
  logic [PW-1:0] spi_exp_q [$];
  logic          dsp_req = 1'b0, spi_req = 1'b0;
  logic          dsp_req_d = 1'b0, spi_req_d = 1'b0;
  logic [PW-1:0] mon_exp;

  always @(posedge clk) begin
    dsp_req_d <= dsp_req;
    spi_req_d <= spi_req;
  end

  always @(negedge clk) begin
    if (dsp_req_d) begin
      total++;
      if (dsp_exp_q.size() == 0) begin
        bad++;
        $display("FAIL dsp_rd: got %h with no expected entry", dsp_rd_data);
      end else begin
        mon_exp = dsp_exp_q.pop_front();
        if (dsp_rd_data !== mon_exp) begin
          bad++;
          $display("FAIL dsp_rd @%0t: got %h want %h", $time, dsp_rd_data, mon_exp);
        end
      end
    end
    if (spi_req_d) begin
      total++;
      if (spi_exp_q.size() == 0) begin
        bad++;
        $display("FAIL spi_rd: got %h with no expected entry", spi_rd_data);
      end else begin
        mon_exp = spi_exp_q.pop_front();
        if (spi_rd_data !== mon_exp) begin
          bad++;
          $display("FAIL spi_rd @%0t: got %h want %h", $time, spi_rd_data, mon_exp);
        end
      end
    end
  end

  function automatic logic [PW-1:0] init_val(input int a);
    return 36'hC_0000_0000 + 36'(a) * 36'h0_0001_0101;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One clock; when checking is on, a DSP read is issued and its expectation queued.
  task automatic tick_at(input bit fixed, input logic [AW-1:0] a);
    if (chk_en) begin
      dsp_rd_addr = fixed ? a : AW'($urandom_range(0, DEPTH - 1));
      dsp_exp_q.push_back(m_bank[exp_active][dsp_rd_addr]);
      dsp_req = 1'b1;
    end else begin
      dsp_req = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_at(1'b0, '0);
  endtask

  task automatic dsp_read(input logic [AW-1:0] a);
    tick_at(1'b1, a);
  endtask

  task automatic spi_read(input logic [AW-1:0] a);
    spi_rd_addr = a;
    spi_exp_q.push_back(m_bank[~exp_active][a]);
    spi_req = 1'b1;
    tick();
    spi_req = 1'b0;
  endtask

  task automatic spi_write(input logic [AW-1:0] a, input logic [PW-1:0] d, input bit accepted);
    spi_wr_addr   = a;
    spi_wr_data   = d;
    spi_wr_enable = 1'b1;
    if (accepted) m_bank[~exp_active][a] = d;
    tick();
    spi_wr_enable = 1'b0;
  endtask

  task automatic spi_begin();
    spi_active = 1'b1;
    tick();
  endtask

  task automatic spi_end(input bit valid, input bit fs);
    spi_valid   = valid;
    frame_start = fs;
    spi_active  = 1'b0;
    tick();
    frame_start = 1'b0;
    spi_valid   = 1'b0;
  endtask

  // Frame boundary while armed: swap, then count busy cycles through the copy.
  task automatic commit_frame(input bit inject);
    int n;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    exp_active = ~exp_active;
    chk("active_bank_after_swap", active_bank, exp_active);
    chk("pending_cleared", commit_pending, 0);
    n = 0;
    while (busy && n < DEPTH + 8) begin
      n++;
      if (inject && n == 3) begin
        spi_wr_addr   = 5;
        spi_wr_data   = 36'h123;
        spi_wr_enable = 1'b1;
      end
      tick();
      spi_wr_enable = 1'b0;
    end
    chk("busy_cycles", n, DEPTH + 1);
    for (int i = 0; i < DEPTH; i++) m_bank[~exp_active][i] = m_bank[exp_active][i];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(posedge clk);
    #1;
    chk("rst_active_bank", active_bank, 0);
    chk("rst_pending", commit_pending, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", wr_overrun, 0);
    chk("rst_dsp_rd_data", dsp_rd_data, 0);
    chk("rst_spi_rd_data", spi_rd_data, 0);
    rst = 1'b0;
    tick();

    // Reset asserted mid-COPY with overrun set
    spi_begin();
    spi_write(0, 36'h1, 1'b1);
    spi_end(1'b1, 1'b0);
    chk("t1_pending", commit_pending, 1);
    spi_write(1, 36'h2, 1'b0);
    chk("t1_overrun", wr_overrun, 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    chk("t1_busy", busy, 1);
    chk("t1_active", active_bank, 1);
    rst = 1'b1;
    #1;
    chk("t1_rst_active", active_bank, 0);
    chk("t1_rst_pending", commit_pending, 0);
    chk("t1_rst_busy", busy, 0);
    chk("t1_rst_overrun", wr_overrun, 0);
    tick();
    rst = 1'b0;
    exp_active = 1'b0;
    tick();

    // Load the full map and commit so both banks are known
    spi_begin();
    for (int a = 0; a < DEPTH; a++) spi_write(AW'(a), init_val(a), 1'b1);
    spi_end(1'b1, 1'b0);
    commit_frame(1'b0);
    chk_en = 1'b1;

    // Valid commit of addr 2
    spi_begin();
    spi_write(2, 36'h0_0000_0AAA, 1'b1);
    spi_end(1'b1, 1'b0);
    chk("t2_pending", commit_pending, 1);
    dsp_read(2);
    commit_frame(1'b0);
    dsp_read(2);
    spi_read(2);

    // Transaction ending with spi_valid low does not arm
    spi_begin();
    spi_write(3, 36'h333, 1'b1);
    spi_end(1'b0, 1'b0);
    chk("t3_pending", commit_pending, 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    chk("t3_no_swap", active_bank, exp_active);
    chk("t3_not_busy", busy, 0);
    spi_read(3);
    dsp_read(3);

    // frame_start coincident with arming fall is ignored; write in ARMED is dropped
    spi_begin();
    spi_write(7, 36'h777, 1'b1);
    spi_end(1'b1, 1'b1);
    chk("t5_pending", commit_pending, 1);
    tick();
    tick();
    chk("t5_no_swap_yet", active_bank, exp_active);
    chk("t5_still_pending", commit_pending, 1);
    spi_write(9, 36'h999, 1'b0);
    chk("armed_drop_overrun", wr_overrun, 1);

    // Swap on the next frame_start, with a write injected during COPY
    commit_frame(1'b1);
    chk("t4_overrun", wr_overrun, 1);
    spi_read(5);
    spi_read(7);
    spi_read(3);
    spi_read(9);
    for (int i = 0; i < 6; i++) tick();

    // Overrun clears on an spi_active rise in IDLE
    spi_begin();
    chk("overrun_cleared", wr_overrun, 0);
    spi_end(1'b0, 1'b0);

    chk_en = 1'b0;
    tick();
    tick();
    chk("dsp_queue_drained", dsp_exp_q.size(), 0);
    chk("spi_queue_drained", spi_exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
